// File: rtl/i2c_mst_single_byte_if.sv
// Host command handshake and open-drain bus signals for i2c_mst_single_byte.
// Member names are seen from the master: i_* flow into it, o_* flow out of it.
interface i2c_mst_single_byte_if;
    logic       i_start;
    logic       i_rw;
    logic [6:0] i_addr;
    logic [7:0] i_wdata;
    logic       i_scl;
    logic       i_sda;
    logic       o_scl;
    logic       o_sda;
    logic       o_ready;
    logic       o_done;
    logic       o_nack;
    logic [7:0] o_rdata;

    modport master (
        input  i_start, i_rw, i_addr, i_wdata, i_scl, i_sda,
        output o_scl, o_sda, o_ready, o_done, o_nack, o_rdata
    );

    modport slave (
        output i_start, i_rw, i_addr, i_wdata, i_scl, i_sda,
        input  o_scl, o_sda, o_ready, o_done, o_nack, o_rdata
    );
endinterface

// File: rtl/i2c_mst_single_byte.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP per command.
// Define I2C_MST_CLK_STRETCH_EN to let a slave stretch SCL by holding it low.
module i2c_mst_single_byte #(
    parameter int NUM_CLKS_SCL_LO = 78,
    parameter int NUM_CLKS_SCL_HI = 74,
    parameter int NUM_CLKS_T_BUF  = 80,
    parameter int WIDTH_CNT       = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    i2c_mst_single_byte_if.master bus
);
    localparam logic [WIDTH_CNT-1:0] LP_LO_MID    = WIDTH_CNT'(NUM_CLKS_SCL_LO / 2);
    localparam logic [WIDTH_CNT-1:0] LP_LO_LAST   = WIDTH_CNT'(NUM_CLKS_SCL_LO - 1);
    localparam logic [WIDTH_CNT-1:0] LP_HI_LAST   = WIDTH_CNT'(NUM_CLKS_SCL_HI - 1);
    localparam logic [WIDTH_CNT-1:0] LP_TBUF_LAST = WIDTH_CNT'(NUM_CLKS_T_BUF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP, S_TBUF
    } state_t;

    state_t               r_state;
    logic [WIDTH_CNT-1:0] r_cnt;
    logic                 r_hi;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic [7:0]           r_wdata;
    logic                 r_rw;
    logic                 r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic                 r_scl, r_sda, r_ready, r_done, r_nack;
    logic [7:0]           r_rdata;
    logic                 w_hi_run;
    logic                 w_sda_bit;

    assign bus.o_scl   = r_scl;
    assign bus.o_sda   = r_sda;
    assign bus.o_ready = r_ready;
    assign bus.o_done  = r_done;
    assign bus.o_nack  = r_nack;
    assign bus.o_rdata = r_rdata;

`ifdef I2C_MST_CLK_STRETCH_EN
    assign w_hi_run = r_scl_s2;
`else
    // SCL is still synchronized but never holds back the high-phase count.
    assign w_hi_run = r_scl_s2 | 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= bus.i_scl;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= bus.i_sda;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // Level put on SDA at mid low phase; acks and read bits leave the line released.
    always_comb begin
        w_sda_bit = 1'b1;
        case (r_state)
            S_ADDR:  w_sda_bit = r_shift[7];
            S_DATA:  w_sda_bit = r_rw | r_shift[7];
            S_STOP:  w_sda_bit = 1'b0;
            default: w_sda_bit = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= 1'b0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_wdata <= 8'h00;
            r_rw    <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start && r_ready) begin
                        r_shift <= {bus.i_addr, bus.i_rw};
                        r_rw    <= bus.i_rw;
                        r_wdata <= bus.i_wdata;
                        r_nack  <= 1'b0;
                        r_rdata <= 8'h00;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_sda <= 1'b0;
                    if (r_cnt == LP_HI_LAST) begin
                        r_scl   <= 1'b0;
                        r_cnt   <= '0;
                        r_hi    <= 1'b0;
                        r_bit   <= 3'd7;
                        r_state <= S_ADDR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TBUF: begin
                    if (r_cnt == LP_TBUF_LAST) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!r_hi) begin
                        if (r_cnt == LP_LO_MID) r_sda <= w_sda_bit;
                        if (r_cnt == LP_LO_LAST) begin
                            r_scl <= 1'b1;
                            r_hi  <= 1'b1;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_hi_run) begin
                        if (r_cnt != LP_HI_LAST) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            // Last high-phase cycle: sample SDA and close the bit.
                            r_cnt <= '0;
                            r_hi  <= 1'b0;
                            if (r_state != S_STOP) r_scl <= 1'b0;
                            case (r_state)
                                S_ADDR: begin
                                    r_shift <= {r_shift[6:0], 1'b0};
                                    if (r_bit == 3'd0) r_state <= S_ADDR_ACK;
                                    else               r_bit   <= r_bit - 1'b1;
                                end
                                S_ADDR_ACK: begin
                                    if (r_sda_s2) begin
                                        r_nack  <= 1'b1;
                                        r_state <= S_STOP;
                                    end else begin
                                        r_shift <= r_wdata;
                                        r_bit   <= 3'd7;
                                        r_state <= S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    r_shift <= {r_shift[6:0], 1'b0};
                                    if (r_rw) r_rdata <= {r_rdata[6:0], r_sda_s2};
                                    if (r_bit == 3'd0) r_state <= S_DATA_ACK;
                                    else               r_bit   <= r_bit - 1'b1;
                                end
                                S_DATA_ACK: begin
                                    if (!r_rw && r_sda_s2) r_nack <= 1'b1;
                                    r_state <= S_STOP;
                                end
                                S_STOP: begin
                                    r_sda   <= 1'b1;
                                    r_done  <= 1'b1;
                                    r_state <= S_TBUF;
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_mst_single_byte.sv
// Bench for i2c_mst_single_byte: a behavioural slave on the wired-AND bus plus a
// transaction-level model of the expected nack/rdata/slave-data outcome.
module tb_i2c_mst_single_byte;
    localparam int LO   = 10;
    localparam int HI   = 8;
    localparam int TBUF = 12;
    localparam logic [6:0] SLV_ADDR = 7'h51;
`ifdef I2C_MST_CLK_STRETCH_EN
    // High phase is counted once the two-flop synchronizer reports SCL high.
    localparam int EXP_HI = HI + 2;
`else
    localparam int EXP_HI = HI;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    i2c_mst_single_byte_if bus();

    i2c_mst_single_byte #(
        .NUM_CLKS_SCL_LO(LO),
        .NUM_CLKS_SCL_HI(HI),
        .NUM_CLKS_T_BUF (TBUF),
        .WIDTH_CNT      (8)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
    );

    logic sl_scl = 1'b1;
    logic sl_sda = 1'b1;
    wire  w_scl  = bus.o_scl & sl_scl;
    wire  w_sda  = bus.o_sda & sl_sda;
    assign bus.i_scl = w_scl;
    assign bus.i_sda = w_sda;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural slave at SLV_ADDR, reacting to bus edges and START/STOP conditions.
    logic       p_scl = 1'b1, p_sda = 1'b1;
    logic       sl_act = 1'b0, sl_sel = 1'b0, sl_rd = 1'b0;
    logic [7:0] sl_sh = 8'h00, sl_rx = 8'h00, sl_tx = 8'h00, sl_data = 8'h00;
    int         sl_k = 0;
    int         stop_edges = 0;
`ifdef I2C_MST_CLK_STRETCH_EN
    logic       stretch_arm = 1'b0;
    event       ev_stretch;
`endif

    always @(w_scl or w_sda or rstn) begin
        if (!rstn) begin
            sl_act = 1'b0;
            sl_sda = 1'b1;
        end else if (w_scl && p_scl && p_sda && !w_sda) begin
            sl_act = 1'b1;
            sl_k   = 0;
            sl_sel = 1'b0;
            sl_sda = 1'b1;
        end else if (w_scl && p_scl && !p_sda && w_sda) begin
            if (sl_act) stop_edges = sl_k;
            sl_act = 1'b0;
            sl_sda = 1'b1;
        end else if (sl_act && w_scl && !p_scl) begin
            sl_k++;
            if (sl_k <= 8) sl_sh = {sl_sh[6:0], w_sda};
            else if (sl_k >= 10 && sl_k <= 17) sl_rx = {sl_rx[6:0], w_sda};
        end else if (sl_act && !w_scl && p_scl) begin
`ifdef I2C_MST_CLK_STRETCH_EN
            if (sl_k == 3 && stretch_arm) -> ev_stretch;
`endif
            if (sl_k == 8) begin
                sl_sel = (sl_sh[7:1] == SLV_ADDR);
                sl_rd  = sl_sh[0];
                if (sl_sel) sl_sda = 1'b0;
            end else if (sl_k == 9) begin
                sl_sda = (sl_sel && sl_rd) ? sl_tx[7] : 1'b1;
            end else if (sl_k >= 10 && sl_k <= 16) begin
                sl_sda = (sl_sel && sl_rd) ? sl_tx[3'(16 - sl_k)] : 1'b1;
            end else if (sl_k == 17) begin
                if (sl_sel && !sl_rd) begin
                    sl_sda  = 1'b0;
                    sl_data = sl_rx;
                end else begin
                    sl_sda = 1'b1;
                end
            end else begin
                sl_sda = 1'b1;
            end
        end
        p_scl = w_scl;
        p_sda = w_sda;
    end

`ifdef I2C_MST_CLK_STRETCH_EN
    initial begin
        forever begin
            @(ev_stretch);
            sl_scl = 1'b0;
            repeat (200) @(posedge clk);
            #2 sl_scl = 1'b1;
        end
    end
`endif

    // SCL high-pulse width and o_done pulse monitor.
    int   hi_w = 0, hi_bad = 0, n_done = 0;
    logic hi_meas = 1'b0, m_prev = 1'b1;
    always @(negedge clk) begin
        if (bus.o_ready || !rstn) hi_meas <= 1'b0;
        else if (w_scl && !m_prev) begin
            hi_meas <= 1'b1;
            hi_w    <= 1;
        end else if (w_scl && hi_meas) hi_w <= hi_w + 1;
        else if (!w_scl && m_prev && hi_meas) begin
            if (hi_w != EXP_HI) hi_bad <= hi_bad + 1;
            hi_meas <= 1'b0;
        end
        m_prev <= w_scl;
        if (bus.o_done) n_done <= n_done + 1;
    end

    logic [7:0] exp_slv = 8'h00;

    task automatic wait_ready();
        int t = 0;
        while (!bus.o_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_val("idle_ready", 32'(bus.o_ready), 32'd1);
    endtask

    task automatic wait_done(input string tag, input bit noise);
        int t = 0;
        while (!bus.o_done && t < 20000) begin
            if (noise) begin
                bus.i_start = 1'($urandom_range(0, 1));
                bus.i_rw    = 1'($urandom_range(0, 1));
                bus.i_addr  = 7'($urandom);
                bus.i_wdata = 8'($urandom);
            end
            @(negedge clk);
            t++;
        end
        bus.i_start = 1'b0;
        check_val(tag, 32'(bus.o_done), 32'd1);
    endtask

    task automatic do_txn(input bit rw, input logic [6:0] addr, input logic [7:0] wdata,
                          input logic [7:0] tx, input bit noise);
        bit         exp_nack;
        logic [7:0] exp_rd;
        int         n0, t;
        exp_nack = (addr != SLV_ADDR);
        exp_rd   = (!exp_nack && rw) ? tx : 8'h00;
        sl_tx    = tx;
        wait_ready();
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_rw    = rw;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        check_val("accept_ready", 32'(bus.o_ready), 32'd0);
        check_val("accept_sda", 32'(bus.o_sda), 32'd0);
        n0 = n_done;
        wait_done("done_seen", noise);
        check_val("done_sda", 32'(bus.o_sda), 32'd1);
        check_val("nack", 32'(bus.o_nack), 32'(exp_nack));
        check_val("rdata", 32'(bus.o_rdata), 32'(exp_rd));
        // Count includes the rising SCL edge of the STOP condition.
        check_val("scl_rises", 32'(stop_edges), exp_nack ? 32'd10 : 32'd19);
        if (!exp_nack && !rw) exp_slv = wdata;
        check_val("slv_data", 32'(sl_data), 32'(exp_slv));
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.o_ready && t < 2000);
        check_val("tbuf_cycles", 32'(t), 32'(TBUF));
        check_val("one_done", 32'(n_done - n0), 32'd1);
        check_val("scl_hi_width", 32'(hi_bad), 32'd0);
        check_val("hold_nack", 32'(bus.o_nack), 32'(exp_nack));
        check_val("hold_rdata", 32'(bus.o_rdata), 32'(exp_rd));
    endtask

    initial begin
        int         t, n0;
        logic [6:0] a;
        logic [7:0] w;
        bus.i_start = 1'b0;
        bus.i_rw    = 1'b0;
        bus.i_addr  = 7'h00;
        bus.i_wdata = 8'h00;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_scl", 32'(bus.o_scl), 32'd1);
        check_val("rst_sda", 32'(bus.o_sda), 32'd1);
        check_val("rst_ready", 32'(bus.o_ready), 32'd1);
        check_val("rst_done", 32'(bus.o_done), 32'd0);
        check_val("rst_nack", 32'(bus.o_nack), 32'd0);
        check_val("rst_rdata", 32'(bus.o_rdata), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        do_txn(1'b0, 7'h51, 8'hAC, 8'h00, 1'b0);
        do_txn(1'b0, 7'h52, 8'h3C, 8'h00, 1'b0);
        do_txn(1'b1, 7'h51, 8'h00, 8'h21, 1'b0);
        do_txn(1'b0, 7'h51, 8'h96, 8'h00, 1'b1);

        // i_start held across two transactions.
        wait_ready();
        n0 = n_done;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_rw    = 1'b0;
        bus.i_addr  = SLV_ADDR;
        bus.i_wdata = 8'h5E;
        t = 0;
        while (!bus.o_done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check_val("hold_done1", 32'(bus.o_done), 32'd1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.o_sda && t < 2000);
        check_val("hold_gap", 32'(t >= TBUF), 32'd1);
        wait_done("hold_done2", 1'b0);
        exp_slv = 8'h5E;
        wait_ready();
        repeat (2 * TBUF) @(negedge clk);
        check_val("hold_two_done", 32'(n_done - n0), 32'd2);
        check_val("hold_still_idle", 32'(bus.o_ready), 32'd1);
        check_val("hold_slv_data", 32'(sl_data), 32'(exp_slv));

`ifdef I2C_MST_CLK_STRETCH_EN
        stretch_arm = 1'b1;
        do_txn(1'b0, SLV_ADDR, 8'hC3, 8'h00, 1'b0);
        stretch_arm = 1'b0;
`endif

        // Reset during data bit 4 of a write.
        wait_ready();
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_rw    = 1'b0;
        bus.i_addr  = SLV_ADDR;
        bus.i_wdata = 8'h0F;
        @(negedge clk);
        bus.i_start = 1'b0;
        t = 0;
        while (sl_k != 13 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check_val("rst_reach_bit4", 32'(sl_k), 32'd13);
        n0 = n_done;
        #1 rstn = 1'b0;
        #1;
        check_val("arst_scl", 32'(bus.o_scl), 32'd1);
        check_val("arst_sda", 32'(bus.o_sda), 32'd1);
        check_val("arst_ready", 32'(bus.o_ready), 32'd1);
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check_val("arst_no_done", 32'(n_done - n0), 32'd0);
        check_val("arst_slv_data", 32'(sl_data), 32'(exp_slv));
        do_txn(1'b0, SLV_ADDR, 8'hA5, 8'h00, 1'b0);

        for (int i = 0; i < 8; i++) begin
            a = 7'($urandom);
            if (a == SLV_ADDR) a = a ^ 7'h01;
            if ($urandom_range(0, 2) != 0) a = SLV_ADDR;
            w = 8'($urandom);
            do_txn(1'($urandom_range(0, 1)), a, w, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
